// File: rtl/conv_pkg.sv
// Shared definitions for the convolution output buffer: geometry helpers
// and the activation selector applied to pixels on their way into the FIFO.
package conv_pkg;

    // Activation applied to each channel before buffering.
    typedef enum logic [0:0] {
        ACT_LINEAR = 1'b0,
        ACT_RELU   = 1'b1
    } act_e;

    // Edge length of a valid (no padding, stride 1) convolution output.
    function automatic int out_dim(input int img_dim, input int kernel_dim);
        return img_dim - kernel_dim + 1;
    endfunction

    // Pixels per output image for a square output of edge od.
    function automatic int num_pixels(input int od);
        return od * od;
    endfunction

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Activation mode selected by the integer RELU parameter.
    function automatic act_e act_mode(input int relu);
        return (relu != 0) ? ACT_RELU : ACT_LINEAR;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// The head entry is read combinationally so the consumer can register it
// on the same edge that pops it.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_write;
    logic             do_read;

    // A write into a full FIFO or a read from an empty one is dropped here,
    // so callers cannot corrupt the pointers.
    assign do_write = wr_en_i && !full_o;
    assign do_read  = rd_en_i && !empty_o;

    // Same index bits with differing wrap bits means the writer lapped the reader.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; the natural overflow of AW+1 bits gives the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers, cleared by reset so buffered contents are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv_obuf.sv
// Output buffer of a convolution layer: applies the activation to each
// channel, queues whole pixels, and shifts them into the next layer's input
// buffer when it is ready. Flags the last pixel of each output image.
module conv_obuf
    import conv_pkg::*;
#(
    parameter int DATA_SIZE       = 8,
    parameter int OUTPUT_CHANNELS = 2,
    parameter int IMG_DIM         = 28,
    parameter int KERNEL_DIM      = 3,
    parameter int FIFO_DEPTH      = 4,
    parameter int RELU            = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DATA_SIZE-1:0]       i_data [OUTPUT_CHANNELS],
    input  logic                       i_next_ready,
    output logic [OUTPUT_CHANNELS-1:0] o_write_enable,
    output logic [DATA_SIZE-1:0]       o_data [OUTPUT_CHANNELS],
    output logic                       o_done
);

    localparam int   OUT_DIM    = out_dim(IMG_DIM, KERNEL_DIM);
    localparam int   NUM_PIXELS = num_pixels(OUT_DIM);
    localparam int   CNT_W      = cnt_width(NUM_PIXELS);
    localparam int   FIFO_W     = OUTPUT_CHANNELS * DATA_SIZE;
    localparam act_e ACT_MODE   = act_mode(RELU);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIXELS - 1);

    logic [FIFO_W-1:0] wr_data;
    logic [FIFO_W-1:0] rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [OUTPUT_CHANNELS-1:0] we_q;
    logic [OUTPUT_CHANNELS-1:0] we_d;
    logic [DATA_SIZE-1:0]       data_q [OUTPUT_CHANNELS];
    logic [DATA_SIZE-1:0]       data_d [OUTPUT_CHANNELS];
    logic                       done_q;
    logic                       done_d;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_d;

    // Ready depends on occupancy alone: a pop on the same edge does not free
    // a slot for the incoming pixel, which keeps this path short.
    assign o_ready = !fifo_full;
    assign push    = i_valid && !fifo_full;
    assign pop     = !fifo_empty && i_next_ready;

    // Per-channel activation, applied before buffering so the FIFO only holds
    // final values. The sign bit alone decides the two's-complement clamp.
    for (genvar gi = 0; gi < OUTPUT_CHANNELS; gi++) begin : g_act
        logic neg;
        assign neg = (ACT_MODE == ACT_RELU) && i_data[gi][DATA_SIZE-1];
        assign wr_data[gi*DATA_SIZE +: DATA_SIZE] = neg ? '0 : i_data[gi];
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next output state: strobe all channels together on a pop, hold the data
    // otherwise, and count pops so the final pixel of an image raises done.
    always_comb begin
        we_d   = '0;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (pop) begin
            we_d   = '1;
            done_d = (cnt_q == LAST_PIX);
            cnt_d  = (cnt_q == LAST_PIX) ? '0 : cnt_q + CNT_W'(1);
            for (int c = 0; c < OUTPUT_CHANNELS; c++) begin
                data_d[c] = rd_data[c*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Output and pixel-count registers; reset restarts the image at pixel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            for (int c = 0; c < OUTPUT_CHANNELS; c++) begin
                data_q[c] <= '0;
            end
        end else begin
            we_q   <= we_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            for (int c = 0; c < OUTPUT_CHANNELS; c++) begin
                data_q[c] <= data_d[c];
            end
        end
    end

    assign o_write_enable = we_q;
    assign o_data         = data_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_conv_obuf.sv
// Bench for conv_obuf: a per-cycle reference model (expected pixels queued at
// acceptance, popped when the block should emit them) runs alongside a vector
// table and hand-written sequences for the multi-cycle corner cases.
module tb_conv_obuf;

    localparam int DW    = 8;
    localparam int CH    = 2;
    localparam int DEPTH = 4;
    localparam int NP    = 9;   // (5-3+1)^2 for dut_a

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a: 5x5 image, 3x3 kernel, ReLU on
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] a_data_i [CH];
    logic          a_nr;
    logic [CH-1:0] a_we;
    logic [DW-1:0] a_data_o [CH];
    logic          a_done;

    // dut_b: default geometry, ReLU off
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] b_data_i [CH];
    logic          b_nr;
    logic [CH-1:0] b_we;
    logic [DW-1:0] b_data_o [CH];
    logic          b_done;

    conv_obuf #(
        .DATA_SIZE(DW), .OUTPUT_CHANNELS(CH), .IMG_DIM(5), .KERNEL_DIM(3),
        .FIFO_DEPTH(DEPTH), .RELU(1)
    ) dut_a (
        .clk(clk), .rst(rst), .i_valid(a_valid), .o_ready(a_ready),
        .i_data(a_data_i), .i_next_ready(a_nr), .o_write_enable(a_we),
        .o_data(a_data_o), .o_done(a_done)
    );

    conv_obuf #(
        .DATA_SIZE(DW), .OUTPUT_CHANNELS(CH), .RELU(0)
    ) dut_b (
        .clk(clk), .rst(rst), .i_valid(b_valid), .o_ready(b_ready),
        .i_data(b_data_i), .i_next_ready(b_nr), .o_write_enable(b_we),
        .o_data(b_data_o), .o_done(b_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] relu8(input logic [7:0] x);
        return x[7] ? 8'h00 : x;
    endfunction

    // ---------------- reference model / scoreboard for dut_a ----------------
    logic [15:0] mq [$];          // {ch1, ch0} expected, in acceptance order
    logic        e_we;
    logic [7:0]  e_d0, e_d1;
    logic        e_done;
    int          ecnt;
    logic        p_valid, p_nr;
    logic [7:0]  p_d0, p_d1;
    int          rst_pulses = 0;
    int          rst_handled = 0;
    int          cyc = 0;
    int          strobe_n = 0;
    int          done_idx [$];
    int          strobe_cyc [$];
    int          occ;
    logic        push_ok, pop_ok;
    logic [15:0] ent;

    initial begin
        e_we = 0; e_d0 = 0; e_d1 = 0; e_done = 0; ecnt = 0;
        p_valid = 0; p_nr = 0; p_d0 = 0; p_d1 = 0;
    end

    always @(posedge rst) rst_pulses++;

    // Inputs are only changed a couple of time units after a rising edge, so
    // the values latched at a falling edge are the ones the next edge uses.
    always @(negedge clk) begin
        cyc++;
        if (rst || rst_pulses != rst_handled) begin
            mq.delete();
            ecnt = 0; e_we = 0; e_d0 = 0; e_d1 = 0; e_done = 0;
            rst_handled = rst_pulses;
        end else begin
            occ     = mq.size();
            push_ok = p_valid && (occ < DEPTH);
            pop_ok  = (occ > 0) && p_nr;
            e_we    = 0;
            e_done  = 0;
            if (pop_ok) begin
                ent    = mq.pop_front();
                e_we   = 1;
                e_d1   = ent[15:8];
                e_d0   = ent[7:0];
                e_done = (ecnt == NP - 1);
                ecnt   = e_done ? 0 : ecnt + 1;
            end
            if (push_ok) mq.push_back({relu8(p_d1), relu8(p_d0)});
        end
        chk("sb_ready", a_ready, mq.size() < DEPTH);
        chk("sb_we",    a_we, e_we ? 2'b11 : 2'b00);
        chk("sb_data0", a_data_o[0], e_d0);
        chk("sb_data1", a_data_o[1], e_d1);
        chk("sb_done",  a_done, e_done);
        if (a_we != 0) begin
            strobe_n++;
            strobe_cyc.push_back(cyc);
            if (a_done) done_idx.push_back(strobe_n);
            $display("strobe %0d: ch0=%02h ch1=%02h done=%0b", strobe_n, a_data_o[0], a_data_o[1], a_done);
        end
        p_valid = a_valid; p_nr = a_nr; p_d0 = a_data_i[0]; p_d1 = a_data_i[1];
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_px(input logic [7:0] d0, input logic [7:0] d1);
        int t;
        a_valid = 1; a_data_i[0] = d0; a_data_i[1] = d1;
        for (t = 0; t < 50 && !a_ready; t++) begin
            @(posedge clk); #2;
        end
        chk("push_timeout", (t < 50), 1'b1);
        @(posedge clk); #2;
        a_valid = 0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("rst_we",    a_we, 2'b00);
        chk("rst_data0", a_data_o[0], 8'h00);
        chk("rst_data1", a_data_o[1], 8'h00);
        chk("rst_done",  a_done, 1'b0);
        chk("rst_ready", a_ready, 1'b1);
        rst = 0;
        a_valid = 0;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d0, d1;
        logic       nr;
        logic       e_rdy;
        logic [1:0] e_we;
        logic [7:0] e_d0, e_d1;
        logic       e_done;
    } vec_t;

    vec_t tbl [12];
    int   s0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_valid = 0; a_nr = 0; a_data_i[0] = 0; a_data_i[1] = 0;
        b_valid = 0; b_nr = 0; b_data_i[0] = 0; b_data_i[1] = 0;

        // Single pixel, then fill to full with backpressure and drain.
        tbl[0]  = '{1'b1, 8'h05, 8'hFB, 1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 8'h05, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b00, 8'h05, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 2'b00, 8'h05, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 8'h80, 8'hFF, 1'b0, 1'b1, 2'b00, 8'h05, 8'h00, 1'b0};
        tbl[5]  = '{1'b1, 8'h10, 8'hF0, 1'b0, 1'b1, 2'b00, 8'h05, 8'h00, 1'b0};
        tbl[6]  = '{1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 2'b00, 8'h05, 8'h00, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 8'h7F, 8'h01, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 8'h10, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11, 8'h11, 8'h22, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 8'h11, 8'h22, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("init_ready", a_ready, 1'b1);
        chk("init_we",    a_we, 2'b00);
        chk("init_data0", a_data_o[0], 8'h00);
        chk("init_done",  a_done, 1'b0);
        rst = 0;

        // Vector table: drive, let one edge pass, compare.
        for (int i = 0; i < 12; i++) begin
            a_valid = tbl[i].v; a_data_i[0] = tbl[i].d0; a_data_i[1] = tbl[i].d1;
            a_nr = tbl[i].nr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ready", i), a_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_we", i),    a_we, tbl[i].e_we);
            chk($sformatf("vec%0d_data0", i), a_data_o[0], tbl[i].e_d0);
            chk($sformatf("vec%0d_data1", i), a_data_o[1], tbl[i].e_d1);
            chk($sformatf("vec%0d_done", i),  a_done, tbl[i].e_done);
            #1;
        end
        a_valid = 0; a_nr = 0;

        // Backpressure: four accepted, fifth held until a slot opens.
        s0 = strobe_n;
        for (int i = 0; i < 4; i++) push_px(8'h20 + 8'(i), 8'h30 + 8'(i));
        a_valid = 1; a_data_i[0] = 8'h24; a_data_i[1] = 8'h34;
        repeat (3) begin
            @(posedge clk); #2;
            chk("bp_ready_low", a_ready, 1'b0);
        end
        a_nr = 1;
        @(posedge clk); #2;
        chk("bp_no_bypass_ready", a_ready, 1'b1);
        @(posedge clk); #2;
        a_valid = 0;
        repeat (8) @(posedge clk);
        #2;
        chk("bp_strobes", strobe_n - s0, 5);

        // Simultaneous push and pop with two entries buffered.
        a_nr = 0;
        s0 = strobe_n;
        push_px(8'h41, 8'h51);
        push_px(8'h42, 8'h52);
        a_valid = 1; a_data_i[0] = 8'h43; a_data_i[1] = 8'h53; a_nr = 1;
        @(posedge clk); #2;
        a_valid = 0; a_nr = 0;
        @(posedge clk); #2;
        chk("sim_one_out", strobe_n - s0, 1);
        a_nr = 1;
        repeat (5) @(posedge clk);
        #2;
        chk("sim_strobes", strobe_n - s0, 3);

        // Reset with a full FIFO discards everything.
        a_nr = 0;
        for (int i = 0; i < 4; i++) push_px(8'h60 + 8'(i), 8'h01);
        chk("pre_rst_full", a_ready, 1'b0);
        pulse_rst();
        s0 = strobe_n;
        a_nr = 1;
        repeat (6) @(posedge clk);
        #2;
        chk("rst_discard", strobe_n - s0, 0);

        // Streaming two images back-to-back at one pixel per cycle.
        s0 = strobe_n;
        done_idx.delete();
        strobe_cyc.delete();
        a_valid = 1;
        for (int i = 0; i < 18; i++) begin
            a_data_i[0] = 8'(i + 1); a_data_i[1] = 8'h80 | 8'(i);
            @(posedge clk); #2;
        end
        a_valid = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("stream_strobes", strobe_n - s0, 18);
        chk("stream_span", (strobe_cyc.size() == 18) ? strobe_cyc[17] - strobe_cyc[0] : -1, 17);
        chk("stream_done_cnt", done_idx.size(), 2);
        chk("stream_done_1", (done_idx.size() > 0) ? done_idx[0] - s0 : -1, 9);
        chk("stream_done_2", (done_idx.size() > 1) ? done_idx[1] - s0 : -1, 18);

        // Reset after four pixels of an image; the next image counts from 0.
        a_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_data_i[0] = 8'h70 + 8'(i); a_data_i[1] = 8'h01;
            @(posedge clk); #2;
        end
        a_valid = 0;
        repeat (3) @(posedge clk);
        pulse_rst();
        s0 = strobe_n;
        done_idx.delete();
        a_valid = 1;
        for (int i = 0; i < 9; i++) begin
            a_data_i[0] = 8'h08 + 8'(i); a_data_i[1] = 8'hFE;
            @(posedge clk); #2;
        end
        a_valid = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_rst_strobes", strobe_n - s0, 9);
        chk("mid_rst_done_cnt", done_idx.size(), 1);
        chk("mid_rst_done_idx", (done_idx.size() > 0) ? done_idx[0] - s0 : -1, 9);

        // ReLU disabled: negative values pass through.
        b_nr = 1; b_valid = 1; b_data_i[0] = 8'h80; b_data_i[1] = 8'hC3;
        @(posedge clk); #2;
        b_valid = 0;
        chk("nr_after_push_we", b_we, 2'b00);
        @(posedge clk); #1;
        chk("norelu_we",    b_we, 2'b11);
        chk("norelu_data0", b_data_o[0], 8'h80);
        chk("norelu_data1", b_data_o[1], 8'hC3);
        chk("norelu_done",  b_done, 1'b0);
        chk("norelu_ready", b_ready, 1'b1);
        @(posedge clk); #1;
        chk("norelu_we_once", b_we, 2'b00);
        chk("norelu_hold",    b_data_o[0], 8'h80);

        chk("final_sb_empty", mq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_obuf.md
CONV_OBUF -- requirements
Module: conv_obuf

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, bits per activation.
REQ-002 SHALL have parameter OUTPUT_CHANNELS, default 2, channels produced per pixel.
REQ-003 SHALL have parameter IMG_DIM, default 28, input image edge of this layer.
REQ-004 SHALL have parameter KERNEL_DIM, default 3, kernel edge.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, pixel entries buffered; power of two, >=2.
REQ-006 SHALL have parameter RELU, default 1; 1 clamps negative (signed) values to 0, 0 passes data unchanged.
REQ-007 SHALL derive OUT_DIM = IMG_DIM-KERNEL_DIM+1 and NUM_PIXELS = OUT_DIM**2.
REQ-008 clk  input  1  single clock, all logic on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-high.
REQ-010 i_valid  input  1  upstream pixel (all channels) present on i_data.
REQ-011 o_ready  output  1  block can accept a pixel this cycle.
REQ-012 i_data  input  [DATA_SIZE-1:0] x OUTPUT_CHANNELS (unpacked)  one activation per channel.
REQ-013 i_next_ready  input  1  downstream input buffer may be written this cycle.
REQ-014 o_write_enable  output  [OUTPUT_CHANNELS-1:0]  per-channel shift strobe to next layer input buffer.
REQ-015 o_data  output  [DATA_SIZE-1:0] x OUTPUT_CHANNELS (unpacked)  activation per channel, valid with o_write_enable.
REQ-016 o_done  output  1  one-cycle pulse coincident with the last pixel of an image.

Function
REQ-017 SHALL accept a pixel (push) on a rising edge where i_valid && o_ready.
REQ-018 SHALL drive o_ready = !full, combinational from occupancy only; no bypass when full, even if a pop occurs that cycle.
REQ-019 SHALL pop the head entry on a rising edge where !empty && i_next_ready.
REQ-020 SHALL register outputs: edge after a pop, o_write_enable = all ones and o_data = popped entry; otherwise o_write_enable = 0 and o_data holds last value.
REQ-021 SHALL give latency of two rising edges from accept to o_write_enable high when FIFO empty and i_next_ready high; a pushed entry is not poppable on its push edge.
REQ-022 SHALL support simultaneous push and pop in one cycle (when not full), occupancy unchanged.
REQ-023 SHALL sustain one pixel per cycle in steady state with i_valid and i_next_ready held high.
REQ-024 SHALL apply ReLU (when RELU=1) at push time, per channel, treating data as two's complement.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit.
REQ-026 SHALL count pops 0..NUM_PIXELS-1; on the pop with count NUM_PIXELS-1, raise o_done on the same output edge as o_write_enable and wrap count to 0.
REQ-027 SHALL ignore i_valid while o_ready is low; upstream holds data.
REQ-028 SHALL never assert o_write_enable partially; all channel bits are equal.

Reset
REQ-029 SHALL on rst: empty FIFO, pointers 0, pixel count 0, o_write_enable 0, o_data 0, o_done 0; o_ready becomes 1 combinationally.
REQ-030 SHALL discard all buffered pixels on rst asserted mid-image; the next image restarts count at 0.

Structure
REQ-031 SHALL place OUT_DIM/NUM_PIXELS derivation functions and the activation type in shared package conv_pkg.
REQ-032 SHALL instantiate one sub-module sync_fifo (width OUTPUT_CHANNELS*DATA_SIZE, depth FIFO_DEPTH, full/empty flags); counter, ReLU and output register stay in conv_obuf.

Verification
REQ-033 Single pixel: defaults, push {8'h05,8'hFB} with i_next_ready=1 -> two edges later o_write_enable=2'b11, o_data={8'h05,8'h00} (RELU=1), one cycle only.
REQ-034 Backpressure: i_next_ready=0, push 5 pixels back-to-back -> o_ready low after 4 accepted, 5th held; release -> 5 pixels emitted in order, none lost or duplicated.
REQ-035 Streaming: IMG_DIM=5, KERNEL_DIM=3, continuous valid/ready -> 9 strobes on 9 consecutive cycles, o_done high only with 9th; second image o_done again after 9 more.
REQ-036 Simultaneous: FIFO holding 2, push and pop same edge -> occupancy stays 2, order preserved.
REQ-037 Reset mid-image: after 4 of 9 pixels, pulse rst asynchronously between edges -> outputs 0 immediately, o_ready=1; next 9 pixels produce o_done on 9th.
REQ-038 RELU=0: push 8'h80 -> o_data=8'h80 unchanged.
